// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and FSM encoding for the instruction-fetch stage
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam int          PERF_W          = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_skid.sv
// rtl/ifetch_skid.sv - one-entry {valid, instr, pc} holding register for fetch responses
module ifetch_skid #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [31:0]       load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              consume,
    output logic              valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc
);

    // load wins over consume so a refill in the same cycle keeps the entry valid
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
            instr <= 32'h0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - MIPS32 fetch stage and IF/ID register; IFETCH_PERF_CNT_EN adds perf counters
module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4,
`ifdef IFETCH_PERF_CNT_EN
    output logic [PERF_W-1:0] perf_fetch_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt,
`endif
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_f, pc_d;
    logic              inflight, inflight_d;
    logic [ADDR_W-1:0] pc_inflight;
    logic              idv_d;
    logic [31:0]       idi_d;
    logic [ADDR_W-1:0] idp_d;
    logic              id_load;
    logic              skid_load, skid_consume, skid_clear;
    logic              skid_valid;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    assign imem_addr = pc_f;
    assign imem_en   = (state_q == RUN) && (!stall || redirect_en);
    assign halted    = (state_q == HALT);

    ifetch_skid #(.ADDR_W(ADDR_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (skid_clear),
        .load       (skid_load),
        .load_instr (imem_rdata),
        .load_pc    (pc_inflight),
        .consume    (skid_consume),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_f;
        inflight_d   = 1'b0;
        idv_d        = id_valid;
        idi_d        = id_instr;
        idp_d        = id_pc;
        id_load      = 1'b0;
        skid_load    = 1'b0;
        skid_consume = 1'b0;
        skid_clear   = 1'b0;
        if (state_q == HALT || halt_req) begin
            state_d    = HALT;
            idv_d      = 1'b0;
            idi_d      = NOP_INSTR;
            skid_clear = 1'b1;
        end else if (redirect_en) begin
            // the request issued alongside a redirect is wrong-path, so it is never marked inflight
            pc_d       = redirect_pc & ~ADDR_W'(3);
            skid_clear = 1'b1;
            if (flush || !stall) begin
                idv_d = 1'b0;
                idi_d = NOP_INSTR;
            end
        end else if (stall) begin
            skid_load = inflight;
            if (flush) begin
                idv_d = 1'b0;
                idi_d = NOP_INSTR;
            end
        end else begin
            pc_d       = pc_f + ADDR_W'(4);
            inflight_d = 1'b1;
            if (skid_valid) begin
                idv_d        = 1'b1;
                idi_d        = skid_instr;
                idp_d        = skid_pc;
                skid_consume = 1'b1;
                skid_load    = inflight;
            end else if (inflight) begin
                idv_d = 1'b1;
                idi_d = imem_rdata;
                idp_d = pc_inflight;
            end else begin
                idv_d = 1'b0;
                idi_d = NOP_INSTR;
            end
            id_load = idv_d && !flush;
            if (flush) begin
                idv_d = 1'b0;
                idi_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_f        <= ADDR_W'(RESET_PC);
            inflight    <= 1'b0;
            pc_inflight <= '0;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= '0;
            id_pc4      <= '0;
        end else begin
            state_q     <= state_d;
            pc_f        <= pc_d;
            inflight    <= inflight_d;
            pc_inflight <= pc_f;
            id_valid    <= idv_d;
            id_instr    <= idi_d;
            id_pc       <= idp_d;
            id_pc4      <= idp_d + ADDR_W'(4);
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (state_q == RUN) begin
            if (id_load && perf_fetch_cnt != {PERF_W{1'b1}})
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (stall && perf_stall_cnt != {PERF_W{1'b1}})
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - self-checking bench for ifetch_stage against an in-order fetch queue model
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        halted;

    ifetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    logic [31:0] key = 32'h0;
    always @(posedge clk) if (imem_en) imem_rdata <= imem_addr ^ key;

    // model: program counter, fetched-but-undelivered words in order, the ID slot
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_req;
    logic [31:0] m_req_pc;
    logic        m_idv;
    logic [31:0] m_idi;
    logic [31:0] m_idp;
    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];

    int n_checks = 0;
    int pass_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000; m_halt = 1'b0; m_req = 1'b0; m_req_pc = 32'h0;
        m_idv = 1'b0; m_idi = 32'h0; m_idp = 32'h0;
        q_instr.delete(); q_pc.delete();
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic re,
                        input logic [31:0] rp, input logic h);
        logic        en;
        logic [31:0] old_pc;
        rst = r; stall = s; flush = f; redirect_en = re; redirect_pc = rp; halt_req = h;
        #1;
        en = !m_halt && (!s || re);
        chk("imem_en", {31'h0, imem_en}, {31'h0, en});
        chk("imem_addr", imem_addr, m_pc);
        chk("halted", {31'h0, halted}, {31'h0, m_halt});
        chk("id_valid", {31'h0, id_valid}, {31'h0, m_idv});
        chk("id_instr", id_instr, m_idv ? m_idi : 32'h0);
        if (m_idv) begin
            chk("id_pc", id_pc, m_idp);
            chk("id_pc4", id_pc4, m_idp + 32'd4);
        end
        chk("skid_overflow", {31'h0, dut.skid_valid && dut.inflight && s}, 32'h0);
        old_pc = m_pc;
        if (r) begin
            model_reset();
        end else if (m_halt || h) begin
            m_halt = 1'b1; m_req = 1'b0; m_idv = 1'b0; m_idi = 32'h0;
            q_instr.delete(); q_pc.delete();
        end else begin
            if (m_req) begin
                q_instr.push_back(m_req_pc ^ key);
                q_pc.push_back(m_req_pc);
            end
            if (re) begin
                q_instr.delete(); q_pc.delete();
                m_pc = {rp[31:2], 2'b00};
                if (f || !s) begin m_idv = 1'b0; m_idi = 32'h0; end
            end else if (s) begin
                if (f) begin m_idv = 1'b0; m_idi = 32'h0; end
            end else begin
                m_pc = m_pc + 32'd4;
                if (q_instr.size() > 0) begin
                    m_idv = 1'b1; m_idi = q_instr.pop_front(); m_idp = q_pc.pop_front();
                end else begin
                    m_idv = 1'b0; m_idi = 32'h0;
                end
                if (f) begin m_idv = 1'b0; m_idi = 32'h0; end
            end
            m_req = en && !re;
            m_req_pc = old_pc;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step(1, 0, 0, 0, 32'h0, 0);
        run(3);                                     // ID shows 3000, then 3004
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 0);
        run(3);                                     // 3008, 300C without gap
        step(0, 0, 0, 1, 32'h0000_3100, 0);
        run(4);
        step(0, 1, 0, 0, 32'h0, 0);                 // fill skid
        step(0, 1, 0, 1, 32'h0000_3200, 0);         // redirect + stall with skid full
        step(0, 1, 0, 0, 32'h0, 0);
        run(4);
        step(0, 0, 1, 0, 32'h0, 0);                 // flush alone
        run(3);
        step(0, 1, 1, 0, 32'h0, 0);                 // flush during stall
        run(3);
        step(0, 0, 0, 1, 32'h0000_3303, 0);         // misaligned target
        run(3);
        step(0, 0, 0, 1, 32'hFFFF_FFF8, 0);         // wrap of pc_f and id_pc4
        run(5);
        step(0, 0, 0, 0, 32'h0, 1);                 // halt
        step(0, 1, 0, 1, 32'h0000_4000, 0);
        step(0, 0, 0, 1, 32'h0000_5000, 0);
        run(2);
        step(1, 0, 0, 0, 32'h0, 0);
        run(4);
        step(0, 1, 0, 0, 32'h0, 0);
        step(1, 1, 0, 1, 32'h0000_6000, 0);         // reset mid-stall/redirect
        run(4);

        key = $urandom;
        step(1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 1500; i++) begin
            logic        r, s, f, re, h;
            logic [31:0] rp;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 99) < 30);
            f  = ($urandom_range(0, 99) < 10);
            re = ($urandom_range(0, 99) < 8);
            h  = ($urandom_range(0, 299) == 0);
            rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                             : (32'h0000_3000 + $urandom_range(0, 4095));
            if (m_halt && $urandom_range(0, 9) == 0) r = 1'b1;
            step(r, s, f, re, rp, h);
        end

        $display("%0d/%0d checks passed", pass_cnt, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS32 core.
- Drives the PC and a synchronous instruction memory with 1-cycle read latency.
- Delivers instruction word, PC and PC+4 to the ID stage, where the control decoder consumes opcode/rt/funct and PC+4 feeds jal writeback.
- Handles hazard stall, branch/jump redirect, ID flush and syscall halt, with a 1-entry skid buffer so no in-flight fetch is lost.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- ADDR_W, 32, PC / byte-address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  ADDR_W  byte address of the request (word aligned).
- imem_rdata  in  32  instruction returned one cycle after the accepted request.
- stall  in  1  hazard unit: hold IF/ID, stop advancing PC.
- flush  in  1  kill the instruction currently in ID (becomes bubble).
- redirect_en  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  target address.
- halt_req  in  1  syscall exit; enter HALT.
- id_valid  out  1  ID slot holds a real instruction.
- id_instr  out  32  instruction word (32'h0 when !id_valid).
- id_pc  out  ADDR_W  PC of id_instr.
- id_pc4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W.
- halted  out  1  high while in HALT.

Behaviour:
- Reset: pc_f=RESET_PC, inflight=0, skid_valid=0, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, state=RUN, halted=0.
- Interface timing: imem_addr=pc_f always. imem_en = (state==RUN) && (!stall || redirect_en).
- Accepted request: sets inflight=1 and pc_inflight=pc_f for the next cycle. Otherwise inflight=0.
- Priority per cycle: rst > halt_req > redirect_en > stall > normal.
- Normal (no stall, no redirect):
  - pc_f += 4.
  - ID loads the skid entry if skid_valid, else imem_rdata/pc_inflight if inflight, else a bubble.
  - A skid entry is consumed before the live response. When the skid is consumed and a response is also inflight, the response is written into the skid in the same cycle, so order is preserved.
- Stall (no redirect):
  - pc_f and all ID outputs hold.
  - If inflight, the response is captured into the skid (skid_valid=1).
  - A skid already full with inflight=1 is impossible, because imem_en=0 during stall. The bench asserts this.
- Redirect:
  - pc_f <= redirect_pc.
  - Response of the current cycle discarded, skid_valid <= 0.
  - ID gets a bubble if flush, else holds when stall, else a bubble.
  - No delay slot: the wrong-path instruction never reaches ID.
- Flush without redirect: id_valid <= 0, id_instr <= 0. Fetch side proceeds per the stall/normal rules.
- FSM RUN -> HALT on halt_req. In HALT:
  - imem_en=0, id_valid=0, skid/inflight cleared, halted=1.
  - Only rst leaves HALT; redirect/stall are ignored.
- redirect_pc with bits[1:0]!=0 is used with bits forced to 00.
- pc_f wraps at 2^ADDR_W.
- rst mid-stall or mid-redirect: full reset values next cycle; first request is RESET_PC.
- Latency: instruction at address A reaches ID two cycles after pc_f==A with no stall.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined: adds outputs perf_fetch_cnt[31:0] (increments for each instruction loaded into ID with id_valid=1) and perf_stall_cnt[31:0] (increments each cycle stall=1 in RUN). Both reset to 0, saturate at 32'hFFFF_FFFF, and freeze in HALT.
- When undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared core package/header (beside Core.vh) holds:
  - `RESET_PC` default and `NOP_INSTR` (32'h0).
  - IFETCH FSM state encodings (RUN=1'b0, HALT=1'b1).
  - Perf-counter width.
- Sub-module ifetch_skid: 1-entry {valid, instr, pc} holding register with load/consume/clear. Everything else is inline.

Test Plan:
- Reset, no stall, imem returns addr-as-data:
  - imem_addr 3000, 3004, 3008 on cycles 0, 1, 2.
  - id_pc=3000, id_instr=3000, id_pc4=3004 at cycle 2. id_valid=0 at cycles 0–1.
- Stall for 3 cycles while ID holds 3004:
  - ID frozen at 3004; 3008 response captured in skid; imem_en=0.
  - On release, ID shows 3008 then 300C with no gap or duplicate.
- redirect_en with redirect_pc=0x3100 while ID holds 3008:
  - Next request is 0x3100; in-flight 300C never appears in ID.
  - 0x3100 reaches ID two cycles later.
- Redirect and stall in the same cycle with skid full: skid cleared, pc_f=target, ID holds; no stale instruction reaches ID after release.
- flush alone: id_valid=0 and id_instr=0 for one cycle; the following instruction arrives normally.
- halt_req: halted=1, imem_en=0, id_valid=0 indefinitely. rst then restarts at RESET_PC. With IFETCH_PERF_CNT_EN, counters read the exact instruction and stall counts of the run and reset to 0.
